message_streamer: RTL
=====================

# message_streamer

Parametrised character-stream sequencer for the LED character display path. Holds `MSG_COUNT` writable messages of up to `MSG_LEN` characters and, on `start`, streams the selected message one character per `COLS` column beats to the downstream glyph/column renderer. Uses a valid/ready handshake so the renderer can stall it. Supports NUL-terminated early end, optional looping, and abort.

## Interface
- `MSG_COUNT`, 4: number of stored messages, ≥1; `SEL_W = max(1, clog2(MSG_COUNT))`.
- `MSG_LEN`, 16: max characters per message, ≥2; `IDX_W = clog2(MSG_LEN)`.
- `CHAR_W`, 8: character code width.
- `COLS`, 4: column beats per character, ≥1; `COL_W = max(1, clog2(COLS))`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin streaming message `msg_sel`; ignored while `busy`.
- `stop`  in  1  abort the current stream.
- `msg_sel`  in  SEL_W  message chosen at `start`; out-of-range values select message 0.
- `loop_en`  in  1  sampled at `start`; 1 means restart at character 0 after the last character.
- `rom_we`  in  1  message-store write strobe.
- `rom_sel`  in  SEL_W  message being written.
- `rom_addr`  in  IDX_W  character slot being written.
- `rom_data`  in  CHAR_W  character code; 0 = NUL terminator.
- `ready`  in  1  downstream accepts the current beat.
- `write`  out  1  beat valid.
- `char_out`  out  CHAR_W  character for this beat.
- `column`  out  COL_W  column index 0..COLS-1.
- `char_index`  out  IDX_W  position of `char_out` in the message.
- `busy`  out  1  stream in progress.
- `done`  out  1  one-cycle pulse on natural completion.

## Operation
- Store: `MSG_COUNT × MSG_LEN × CHAR_W` register array.
  - Written on `rom_we` at any time, including while streaming.
  - Not cleared by reset. Power-up contents are 0.
- States: IDLE, EMIT.
- IDLE, on `start`:
  - Latch `msg_sel` and `loop_en`. Read slot 0.
  - If slot 0 is NUL, stay IDLE and pulse `done` next cycle.
  - Otherwise enter EMIT with `char_index`=0, `column`=0, `char_out`=slot 0.
- EMIT:
  - `write`=1. A beat is accepted when `write && ready`.
  - On accept with `column < COLS-1`: increment `column`.
  - On accept with `column == COLS-1`: set `column`=0 and compute next = `char_index+1`.
    - If next == MSG_LEN or slot[next] is NUL: this is the end.
      - With latched loop on: `char_index`=0 and load slot 0.
      - Otherwise go to IDLE and pulse `done`.
    - Otherwise load slot[next].
- Stall: while `write && !ready`, `char_out`, `column` and `char_index` hold stable.
- Character fetch: a character is fetched when it is loaded. A store write to the currently loaded slot does not change the `char_out` already presented.
- `stop` in EMIT: go to IDLE next cycle. `write` drops, `done` is not pulsed, and any beat accepted in that same cycle still counts. `stop` in IDLE has no effect.
- Same cycle `stop` and `start` in IDLE: `start` wins.
- `busy` = (state == EMIT).
- Reset values: `write`, `char_out`, `column`, `char_index`, `busy` and `done` are all 0. State is IDLE. Latched select and loop are 0.
- Reset mid-stream: outputs return to reset values immediately. No `done` pulse.

## Timing
- Latency from `start` to first `write`: 1 cycle, registered.
- Throughput with `ready` held high: one beat per cycle. An N-character message takes N·COLS cycles, then `write` falls.
- `done` rises in the cycle after the final accepted beat, in the same cycle `busy` falls. It lasts exactly 1 cycle.
- A `start` that arrives in the same cycle `done` is high is accepted.
- All outputs are registered. There is no combinational path from `ready` to `char_out`.

## Test plan
- Basic stream: MSG_LEN=8, COLS=4, message 0 = "MICROSIM", `ready`=1, pulse `start`.
  - Expect 32 beats: `char_out` "M"×4 … "M"×4, `column` cycling 0,1,2,3.
  - Then `done` one cycle later, then `busy`=0.
- Early terminator: message 1 = "HI",NUL.
  - Expect 8 beats: H,H,H,H,I,I,I,I. `done` pulses and `char_index` never exceeds 1.
  - Empty message (slot 0 NUL): no `write`, `done` 1 cycle after `start`.
- Backpressure: drop `ready` randomly during "MICROSIM".
  - Outputs stay stable while stalled.
  - The accepted-beat sequence matches the basic case exactly.
  - Total beats is still 32.
- Loop and stop: `loop_en`=1 with "HI".
  - After I col3 the next beat is H col0, and `done` never pulses.
  - Assert `stop` during beat 11: `write` is 0 the next cycle, `busy` is 0, no `done`.
- Reset and store update: assert `rst_n`=0 mid-stream.
  - All outputs go to 0 asynchronously.
  - After release, a new `start` runs from `char_index` 0.
- Store write while streaming: write slot 3 while slot 1 is shown.
  - The new value appears when char 3 is reached; the current `char_out` is unchanged.
- Out-of-range select: MSG_COUNT=3 with `msg_sel`=3 streams message 0.

Source files
------------

// File: rtl/message_streamer.sv
// -----------------------------------------------------------------------------
// message_streamer
//
// Character-stream sequencer for the LED character display path. Holds
// MSG_COUNT writable messages of up to MSG_LEN characters. On start it streams
// the selected message to the glyph/column renderer. Each character is held
// for COLS column beats. A valid/ready handshake (write/ready) lets the
// renderer stall the stream. A NUL character ends a message early. Streams
// can loop, and can be aborted with stop.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin streaming message msg_sel (ignored while busy)
//   stop       abort the current stream (no done pulse)
//   msg_sel    message chosen at start; out-of-range selects message 0
//   loop_en    sampled at start; restart at character 0 after the last one
//   rom_we     message-store write strobe
//   rom_sel    message being written
//   rom_addr   character slot being written
//   rom_data   character code (0 = NUL terminator)
//   ready      downstream accepts the current beat
//   write      beat valid
//   char_out   character for this beat
//   column     column index 0..COLS-1
//   char_index position of char_out within the message
//   busy       stream in progress
//   done       one-cycle pulse on natural completion
// -----------------------------------------------------------------------------
module message_streamer #(
  parameter int MSG_COUNT = 4,
  parameter int MSG_LEN   = 16,
  parameter int CHAR_W    = 8,
  parameter int COLS      = 4,
  localparam int SEL_W    = (MSG_COUNT > 1) ? $clog2(MSG_COUNT) : 1,
  localparam int IDX_W    = $clog2(MSG_LEN),
  localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [SEL_W-1:0]  msg_sel,
  input  logic              loop_en,
  input  logic              rom_we,
  input  logic [SEL_W-1:0]  rom_sel,
  input  logic [IDX_W-1:0]  rom_addr,
  input  logic [CHAR_W-1:0] rom_data,
  input  logic              ready,
  output logic              write,
  output logic [CHAR_W-1:0] char_out,
  output logic [COL_W-1:0]  column,
  output logic [IDX_W-1:0]  char_index,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE, EMIT} state_t;

  // Message store: not reset, writable at any time.
  logic [CHAR_W-1:0] mem [MSG_COUNT][MSG_LEN];

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              loop_q, loop_d;
  logic [CHAR_W-1:0] char_q, char_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              done_q, done_d;

  logic [SEL_W-1:0]  sel_eff;
  logic [CHAR_W-1:0] start_char;
  logic [CHAR_W-1:0] head_char;
  logic [IDX_W:0]    nxt;
  logic [IDX_W-1:0]  nxt_idx;
  logic [CHAR_W-1:0] nxt_char;
  logic              msg_end;

  always_ff @(posedge clk) begin
    if (rom_we && (int'(rom_sel) < MSG_COUNT) && (int'(rom_addr) < MSG_LEN))
      mem[rom_sel][rom_addr] <= rom_data;
  end

  // Store reads: slot 0 of the requested message at start, slot 0 of the
  // latched message for a loop restart, and the following slot during EMIT.
  // nxt is one bit wider so that reaching MSG_LEN is detectable.
  assign sel_eff    = (int'(msg_sel) < MSG_COUNT) ? msg_sel : '0;
  assign start_char = mem[sel_eff][0];
  assign head_char  = mem[sel_q][0];
  assign nxt        = {1'b0, idx_q} + 1'b1;
  assign nxt_idx    = nxt[IDX_W-1:0];
  assign nxt_char   = mem[sel_q][nxt_idx];
  assign msg_end    = (int'(nxt) >= MSG_LEN) || (nxt_char == '0);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    loop_d  = loop_q;
    char_d  = char_q;
    col_d   = col_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sel_d  = sel_eff;
          loop_d = loop_en;
          if (start_char == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = EMIT;
            idx_d   = '0;
            col_d   = '0;
            char_d  = start_char;
          end
        end
      end
      EMIT: begin
        if (ready) begin
          if (col_q != COL_W'(COLS - 1)) begin
            col_d = col_q + 1'b1;
          end else begin
            col_d = '0;
            if (!msg_end) begin
              idx_d  = nxt_idx;
              char_d = nxt_char;
            end else if (loop_q) begin
              idx_d  = '0;
              char_d = head_char;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        // Abort overrides completion; the beat accepted this cycle still
        // advances column/index above.
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      loop_q  <= 1'b0;
      char_q  <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      loop_q  <= loop_d;
      char_q  <= char_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign write      = (state_q == EMIT);
  assign busy       = (state_q == EMIT);
  assign char_out   = char_q;
  assign column     = col_q;
  assign char_index = idx_q;
  assign done       = done_q;

endmodule
